// File: rtl/irq_arbiter_if.sv
// Trap handshake between irq_arbiter (master) and the pipeline trap logic (slave).
interface irq_arbiter_if;
  logic       irq_req;
  logic [1:0] irq_id;
  logic [4:0] irq_code;
  logic       in_handler;
  logic       irq_ack;
  logic       mret;

  modport master (
    output irq_req,
    output irq_id,
    output irq_code,
    output in_handler,
    input  irq_ack,
    input  mret
  );

  modport slave (
    input  irq_req,
    input  irq_id,
    input  irq_code,
    input  in_handler,
    output irq_ack,
    output mret
  );
endinterface

// File: rtl/irq_arbiter.sv
// Machine interrupt arbiter: synchronises irq_in, maintains mip and issues one trap request at a time.
// Define IRQ_EDGE_LATCH_EN to make mip edge-latched (cleared on ack) instead of level-following.
module irq_arbiter #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    irq_in,
  input  logic [3:0]    mie,
  input  logic          mstatus_mie,
  output logic [3:0]    mip,
  irq_arbiter_if.master bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_HANDLER = 2'd2;

  logic [1:0] state;
  logic       req_q;
  logic [1:0] id_q;
  logic [4:0] code_q;
  logic       in_handler_q;

  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] sync_out;
  logic [3:0] elig;
  logic [1:0] win_id;
  logic [4:0] win_code;
  logic       ack_take;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= irq_in;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign ack_take = (state == ST_REQ) && bus.irq_ack;

`ifdef IRQ_EDGE_LATCH_EN
  logic [3:0] sync_d;
  logic [3:0] mip_q;
  logic [3:0] rise;
  logic [3:0] ack_clr;

  assign rise    = sync_out & ~sync_d;
  assign ack_clr = ack_take ? 4'(4'b0001 << id_q) : '0;

  // Clear is applied before set so a fresh edge in the ack cycle is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_d <= '0;
      mip_q  <= '0;
    end else begin
      sync_d <= sync_out;
      mip_q  <= (mip_q & ~ack_clr) | rise;
    end
  end

  assign mip = mip_q;
`else
  assign mip = sync_out;
`endif

  assign elig = mip & mie & {4{mstatus_mie}};

  // Fixed priority: external > software > timer > platform-local.
  always_comb begin
    win_id = 2'd3;
    if (elig[2]) begin
      win_id = 2'd2;
    end else if (elig[0]) begin
      win_id = 2'd0;
    end else if (elig[1]) begin
      win_id = 2'd1;
    end
  end

  always_comb begin
    win_code = 5'd16;
    case (win_id)
      2'd0:    win_code = 5'd3;
      2'd1:    win_code = 5'd7;
      2'd2:    win_code = 5'd11;
      default: win_code = 5'd16;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      req_q        <= 1'b0;
      id_q         <= '0;
      code_q       <= '0;
      in_handler_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (elig != '0) begin
            state  <= ST_REQ;
            req_q  <= 1'b1;
            id_q   <= win_id;
            code_q <= win_code;
          end
        end
        ST_REQ: begin
          // Ack takes precedence over a same-cycle withdrawal; id stays frozen otherwise.
          if (bus.irq_ack) begin
            state        <= ST_HANDLER;
            req_q        <= 1'b0;
            in_handler_q <= 1'b1;
          end else if (elig == '0) begin
            state <= ST_IDLE;
            req_q <= 1'b0;
          end
        end
        ST_HANDLER: begin
          if (bus.mret) begin
            state        <= ST_IDLE;
            in_handler_q <= 1'b0;
          end
        end
        default: begin
          state        <= ST_IDLE;
          req_q        <= 1'b0;
          in_handler_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.irq_req    = req_q;
  assign bus.irq_id     = id_q;
  assign bus.irq_code   = code_q;
  assign bus.in_handler = in_handler_q;

  a_no_req_in_handler: assert property (@(posedge clk) disable iff (rst)
    !(req_q && in_handler_q));

  a_id_stable: assert property (@(posedge clk) disable iff (rst)
    (req_q && $past(req_q)) |-> $stable(id_q));

endmodule
